ei_mac8x8_feeder: RTL and testbench

Initiator side of the 8x8 MAC PE interface. Accepts a stream of (a,b) byte pairs terminated by `in_last` and drives the PE's `en`/`clr_acc`/`valid_in`/`a_in`/`b_in` pins. It counts returned `valid_out` pulses, captures the final 32-bit accumulator and presents one dot-product result per vector on a valid/ready port. Sits between the operand SRAM readers and one `ei_mac8x8_pipe` instance.

---
 rtl/ei_mac_pkg.sv | 23 ++
 rtl/ei_mac8x8_feeder.sv | 157 +++++++++++++++
 tb/tb_ei_mac8x8_feeder.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ei_mac_pkg.sv
// Shared types and constants for the 8x8 MAC feeder and its PE.
package ei_mac_pkg;

  // Feeder control states: clear the PE, stream operands, wait for the
  // pipeline to empty, capture the accumulator, then offer the result.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_CAPT,
    S_RESULT
  } feeder_state_t;

  // Multiplier latency of the ei_mac8x8_pipe PE in its default build.
  localparam int MAC_LAT = 3;

  // Width of a counter that must hold every value from 0 to max_len.
  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/ei_mac8x8_feeder.sv
// Initiator for one 8x8 MAC PE: streams (a,b) byte pairs into the PE,
// counts the returned valid_out pulses, captures the final accumulator and
// hands one dot product per vector out on a valid/ready port.
module ei_mac8x8_feeder
  import ei_mac_pkg::*;
#(
  parameter int LAT       = MAC_LAT,
  parameter int MAX_LEN   = 256,
  parameter int DRAIN_TMO = LAT + 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_a,
  input  logic [7:0]                 in_b,
  input  logic                       in_last,
  output logic                       mac_en,
  output logic                       mac_clr_acc,
  output logic                       mac_valid_in,
  output logic [7:0]                 mac_a,
  output logic [7:0]                 mac_b,
  input  logic [31:0]                mac_acc_out,
  input  logic                       mac_valid_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [cnt_w(MAX_LEN)-1:0]  res_count,
  output logic                       res_err
);

  localparam int CW = cnt_w(MAX_LEN);
  // A healthy PE always answers within LAT+1 DRAIN cycles, so the timeout
  // is never allowed to be shorter than that.
  localparam int TMO = (DRAIN_TMO > LAT) ? DRAIN_TMO : LAT + 1;
  localparam int TW  = $clog2(TMO + 1);

  localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);

  feeder_state_t state, state_nxt;

  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] rcv_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          err;

  logic accept;
  logic trunc;
  logic vec_end;
  logic rcv_pulse;
  logic drain_done;
  logic drain_tmo;

  // Handshake and drain qualifiers shared by the FSM and the datapath.
  assign accept     = in_valid & in_ready;
  assign trunc      = accept & ~in_last & (issue_cnt == LAST_SLOT);
  assign vec_end    = accept & (in_last | (issue_cnt == LAST_SLOT));
  assign rcv_pulse  = mac_valid_out & ((state == S_STREAM) | (state == S_DRAIN));
  // The pulse arriving this cycle counts, so CAPT follows it immediately.
  assign drain_done = ((rcv_cnt + CW'(mac_valid_out)) == issue_cnt);
  assign drain_tmo  = (tmo_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled only on the clock edge (synchronous); the PE
    // shares this reset, so both sides abandon a vector together.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses <= so every flop sees pre-edge values
      // no matter how the statements are ordered.
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so
    // no path can leave one unassigned and infer a latch.
    state_nxt   = state;
    in_ready    = 1'b0;
    mac_clr_acc = 1'b0;
    res_valid   = 1'b0;
    mac_en      = ~rst;

    unique case (state)
      S_IDLE: begin
        if (in_valid) state_nxt = S_CLR;
      end
      S_CLR: begin
        mac_clr_acc = 1'b1;
        state_nxt   = S_STREAM;
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (vec_end) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done || drain_tmo) state_nxt = S_CAPT;
      end
      S_CAPT: begin
        state_nxt = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand register, issue/receive/timeout counters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_valid_in <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      issue_cnt    <= '0;
      rcv_cnt      <= '0;
      tmo_cnt      <= '0;
      err          <= 1'b0;
      res_data     <= '0;
      res_count    <= '0;
      res_err      <= 1'b0;
    end else begin
      mac_valid_in <= accept;

      if (accept) begin
        mac_a     <= in_a;
        mac_b     <= in_b;
        issue_cnt <= issue_cnt + CW'(1);
      end

      if (rcv_pulse) rcv_cnt <= rcv_cnt + CW'(1);

      if (trunc) err <= 1'b1;
      if ((state == S_DRAIN) && !drain_done && drain_tmo) err <= 1'b1;

      tmo_cnt <= (state == S_DRAIN) ? tmo_cnt + TW'(1) : '0;

      // CLR precedes every issue of a vector, so it never races an accept.
      if (state == S_CLR) begin
        issue_cnt <= '0;
        rcv_cnt   <= '0;
        err       <= 1'b0;
      end

      if (state == S_CAPT) begin
        res_data  <= mac_acc_out;
        res_count <= issue_cnt;
        res_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_ei_mac8x8_feeder.sv
// Bench for ei_mac8x8_feeder driving a behavioural stand-in for the
// ei_mac8x8_pipe PE. A stream-level model predicts each dot product and
// its arrival cycle; a monitor checks results and operand issue per cycle.
module tb_ei_mac8x8_feeder;
  import ei_mac_pkg::*;

  localparam int LAT       = MAC_LAT;
  localparam int MAX_LEN   = 4;
  localparam int DRAIN_TMO = LAT + 4;
  localparam int CW        = cnt_w(MAX_LEN);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_last;
  logic          mac_en;
  logic          mac_clr_acc;
  logic          mac_valid_in;
  logic [7:0]    mac_a;
  logic [7:0]    mac_b;
  logic [31:0]   mac_acc_out;
  logic          mac_valid_out;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [CW-1:0] res_count;
  logic          res_err;

  ei_mac8x8_feeder #(
    .LAT       (LAT),
    .MAX_LEN   (MAX_LEN),
    .DRAIN_TMO (DRAIN_TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_last       (in_last),
    .mac_en        (mac_en),
    .mac_clr_acc   (mac_clr_acc),
    .mac_valid_in  (mac_valid_in),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_acc_out   (mac_acc_out),
    .mac_valid_out (mac_valid_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_count     (res_count),
    .res_err       (res_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- PE stand-in ----------------
  // valid_in seen at an edge emerges as valid_out LAT cycles later; the
  // accumulator adds the product on the edge after valid_out. pe_mute
  // swallows valid_out to emulate a hung PE.
  bit          pe_mute = 1'b0;
  logic [LAT-1:0] pv;
  logic [15:0] pp [LAT];
  logic [31:0] acc;

  assign mac_valid_out = pv[LAT-1] & ~pe_mute;
  assign mac_acc_out   = acc;

  always @(posedge clk) begin
    if (rst) begin
      pv  <= '0;
      acc <= '0;
      for (int i = 0; i < LAT; i++) pp[i] <= '0;
    end else if (mac_en) begin
      pv    <= {pv[LAT-2:0], mac_valid_in};
      pp[0] <= 16'(mac_a) * 16'(mac_b);
      for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
      if (mac_clr_acc)        acc <= '0;
      else if (mac_valid_out) acc <= acc + 32'(pp[LAT-1]);
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          count;
    bit          err;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit         ends;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_edge[int];

  // Stream-level reference: sums products until in_last or MAX_LEN pairs.
  logic [31:0] m_sum = '0;
  int          m_cnt = 0;

  task automatic model_accept(input logic [7:0] a, input logic [7:0] b,
                              input bit last, input int edge_no);
    exp_t e;
    acc_t r;
    m_sum = m_sum + 32'(a) * 32'(b);
    m_cnt++;
    r.a = a;
    r.b = b;
    r.ends = last || (m_cnt == MAX_LEN);
    acc_edge[edge_no] = r;
    if (r.ends) begin
      e.data  = pe_mute ? 32'd0 : m_sum;
      e.count = m_cnt;
      e.err   = !last || pe_mute;
      e.due   = edge_no + (pe_mute ? DRAIN_TMO + 1 : LAT + 2);
      exp_q.push_back(e);
      m_sum = '0;
      m_cnt = 0;
    end
  endtask

  // Offer one pair and hold it until accepted; returns just after the
  // accepting edge with in_valid low.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last);
    bit got;
    got = 1'b0;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      model_accept(a, b, last, cyc + 1);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_results();
    for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(negedge clk);
    check("results_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle operand issue, result latency, stability and data.
  bit          prev_rv = 1'b0;
  bit          prev_rr = 1'b0;
  logic [31:0] prev_d;
  logic [CW-1:0] prev_c;
  logic        prev_e;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 1'b0;
      end else begin
        if (acc_edge.exists(cyc)) begin
          check("mac_valid_in", 32'(mac_valid_in), 32'd1);
          check("mac_a", 32'(mac_a), 32'(acc_edge[cyc].a));
          check("mac_b", 32'(mac_b), 32'(acc_edge[cyc].b));
          if (acc_edge[cyc].ends) check("in_ready_after_end", 32'(in_ready), 32'd0);
        end else begin
          check("mac_valid_in_gap", 32'(mac_valid_in), 32'd0);
        end
        if (prev_rv && !prev_rr) begin
          check("res_valid_held", 32'(res_valid), 32'd1);
          check("res_data_held", res_data, prev_d);
          check("res_count_held", 32'(res_count), 32'(prev_c));
          check("res_err_held", 32'(res_err), 32'(prev_e));
        end
        if (res_valid) check("in_ready_in_result", 32'(in_ready), 32'd0);
        if (res_valid && !prev_rv) begin
          if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
          else check("res_latency", 32'(cyc), 32'(exp_q[0].due));
        end
        if (res_valid && res_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_count", 32'(res_count), 32'(e.count));
          check("res_err", 32'(res_err), 32'(e.err));
        end
        prev_rv = res_valid;
        prev_rr = res_ready;
        prev_d  = res_data;
        prev_c  = res_count;
        prev_e  = res_err;
      end
    end
  end

  // Random consumer back-pressure when enabled.
  bit rand_rr = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rr) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    res_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_mac_valid_in", 32'(mac_valid_in), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mac_en_out_of_reset", 32'(mac_en), 32'd1);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    idle(1);

    // 1: back-to-back three pairs -> 27.
    send(8'd1, 8'd1, 1'b0);
    send(8'd2, 8'd3, 1'b0);
    send(8'd4, 8'd5, 1'b1);
    wait_results();

    // 2: single pair.
    send(8'd255, 8'd255, 1'b1);
    wait_results();

    // 3: gapped input -> 149.
    send(8'd10, 8'd10, 1'b0);
    idle(1);
    send(8'd20, 8'd2, 1'b0);
    idle(1);
    send(8'd3, 8'd3, 1'b1);
    wait_results();

    // 4: truncation at MAX_LEN; pairs 5 and 6 open the next vector.
    for (int i = 0; i < 6; i++) send(8'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    wait_results();

    // 5: consumer stalls in RESULT, then a fresh vector proves the clear.
    res_ready = 1'b0;
    send(8'd3, 8'd4, 1'b1);
    for (int t = 0; t < 50 && !res_valid; t++) @(negedge clk);
    check("stall_res_valid", 32'(res_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_results();
    send(8'd2, 8'd2, 1'b1);
    wait_results();

    // 6a: hung PE -> drain timeout.
    pe_mute = 1'b1;
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    wait_results();
    pe_mute = 1'b0;

    // 6b: reset mid-STREAM abandons the vector.
    send(8'd9, 8'd9, 1'b0);
    send(8'd7, 8'd7, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_mac_en", 32'(mac_en), 32'd0);
    check("midrst_mac_valid_in", 32'(mac_valid_in), 32'd0);
    check("midrst_mac_a", 32'(mac_a), 32'd0);
    check("midrst_mac_b", 32'(mac_b), 32'd0);
    check("midrst_clr_acc", 32'(mac_clr_acc), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_err", 32'(res_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_sum = '0;
    m_cnt = 0;
    idle(12);
    check("midrst_no_result", 32'(res_valid), 32'd0);
    send(8'd6, 8'd7, 1'b1);
    wait_results();

    // Random vectors with gaps, occasional missing last, random back-pressure.
    rand_rr = 1'b1;
    for (int v = 0; v < 30; v++) begin
      len = $urandom_range(1, 5);
      for (int p = 0; p < len; p++) begin
        send(8'($urandom), 8'($urandom),
             (p == len - 1) && ($urandom_range(0, 4) != 0));
        idle($urandom_range(0, 2));
      end
    end
    send(8'($urandom), 8'($urandom), 1'b1);
    rand_rr = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_results();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
